shift_deserializer: RTL and testbench

- Serial-in, parallel-out receiver. It collects a bit stream shifted out one bit at a time by the 4-bit shift register and reassembles it into a WIDTH-bit word.
- Supports MSB-first and LSB-first ordering, selected per word.
- Delivers each completed word through a registered valid/ready output stage.
- Sits between a serial link and downstream parallel logic; one word can be buffered while the next is being assembled.

---
 rtl/shift_pkg.sv | 16 +
 rtl/shift_deser_outreg.sv | 40 ++++
 rtl/shift_deserializer.sv | 126 ++++++++++++
 tb/tb_shift_deserializer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the serial-in/parallel-out receiver.
// State and direction encodings plus the default word width.
package shift_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Same sense as the transmitter's shift-left / shift-right select.
  localparam logic DIR_LSB = 1'b0;
  localparam logic DIR_MSB = 1'b1;

  localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/shift_deser_outreg.sv
// Single-entry valid/ready output register; a completed word that finds the
// slot full and not draining is dropped and flags a sticky overrun.
module shift_deser_outreg #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          load,
  input  logic [DW-1:0] word,
  input  logic          p_ready,
  output logic [DW-1:0] data,
  output logic          valid,
  output logic          overrun
);

  logic accept;

  assign accept = load & (~valid | p_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else if (clr) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else if (accept) begin
      data  <= word;
      valid <= 1'b1;
    end else if (load) begin
      overrun <= 1'b1;
    end else if (valid && p_ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_deserializer.sv
// Serial-in, parallel-out receiver with per-word bit order and a buffered
// valid/ready output. SHIFT_DESER_PARITY_EN adds a trailing even-parity bit.
module shift_deserializer
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             s_in,
  input  logic             s_valid,
  input  logic             msb_first,
  output logic [WIDTH-1:0] p_out,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             busy,
  output logic             overrun
`ifdef SHIFT_DESER_PARITY_EN
  ,
  output logic             parity_err
`endif
);

`ifdef SHIFT_DESER_PARITY_EN
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);
  localparam int OW = WIDTH + 1;
`else
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam int OW = WIDTH;
`endif

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] shreg, shreg_nx, shifted;
  logic             dir_q, dir_nx, dir_eff, done;
  logic [OW-1:0]    word, data;

  // The first bit of a word uses the live msb_first; later bits the latched one.
  assign dir_eff = (state == ST_IDLE) ? msb_first : dir_q;
  assign shifted = (dir_eff == DIR_MSB) ? {shreg[WIDTH-2:0], s_in}
                                        : {s_in, shreg[WIDTH-1:1]};

`ifdef SHIFT_DESER_PARITY_EN
  // On the parity cycle shreg already holds the full data word.
  assign word = {^shreg ^ s_in, shreg};
`else
  assign word = shifted;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    shreg_nx = shreg;
    dir_nx   = dir_q;
    done     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s_valid) begin
          dir_nx   = msb_first;
          shreg_nx = shifted;
          cnt_nx   = CNT_W'(1);
          state_nx = ST_SHIFT;
        end
      end
      default: begin
        if (s_valid) begin
`ifdef SHIFT_DESER_PARITY_EN
          if (cnt != LAST) shreg_nx = shifted;
`else
          shreg_nx = shifted;
`endif
          if (cnt == LAST) begin
            done     = 1'b1;
            cnt_nx   = '0;
            state_nx = ST_IDLE;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      shreg <= '0;
      dir_q <= DIR_LSB;
    end else if (clr) begin
      state <= ST_IDLE;
      cnt   <= '0;
      shreg <= '0;
      dir_q <= DIR_LSB;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      shreg <= shreg_nx;
      dir_q <= dir_nx;
    end
  end

  assign busy = (state == ST_SHIFT);

  shift_deser_outreg #(.DW(OW)) u_outreg (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .load    (done),
    .word    (word),
    .p_ready (p_ready),
    .data    (data),
    .valid   (p_valid),
    .overrun (overrun)
  );

`ifdef SHIFT_DESER_PARITY_EN
  assign p_out      = data[WIDTH-1:0];
  assign parity_err = data[WIDTH];
`else
  assign p_out = data;
`endif

endmodule

// File: tb/tb_shift_deserializer.sv
// Self-checking bench for shift_deserializer (WIDTH=4): directed scenarios
// plus randomized words and randomized backpressure against a word-level model.
module tb_shift_deserializer;

  localparam int W = 4;
`ifdef SHIFT_DESER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         reset, clr, s_in, s_valid, msb_first, p_ready;
  logic [W-1:0] p_out;
  logic         p_valid, busy, overrun;
`ifdef SHIFT_DESER_PARITY_EN
  logic         parity_err;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shift_deserializer #(.WIDTH(W), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .s_in      (s_in),
    .s_valid   (s_valid),
    .msb_first (msb_first),
    .p_out     (p_out),
    .p_valid   (p_valid),
    .p_ready   (p_ready),
    .busy      (busy),
    .overrun   (overrun)
`ifdef SHIFT_DESER_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  // seq lists bits in send order left to right (seq[W-1] is sent first).
  function automatic logic [W-1:0] exp_word(input logic [W-1:0] seq, input logic msb);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < W; k++) begin
      if (msb) r[W-1-k] = seq[W-1-k];
      else     r[k]     = seq[W-1-k];
    end
    return r;
  endfunction

  // All drive tasks start and end just after a falling edge.
  task automatic drive_bit(input logic b, input logic dir);
    s_valid = 1'b1; s_in = b; msb_first = dir;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [W-1:0] seq, input logic dir, input logic toggle);
    for (int k = 0; k < W; k++)
      drive_bit(seq[W-1-k], (k != 0 && toggle) ? ~dir : dir);
`ifdef SHIFT_DESER_PARITY_EN
    drive_bit(^seq, dir);
`endif
  endtask

  task automatic test_reset();
    reset = 1'b0; clr = 1'b0; s_in = 1'b0; s_valid = 1'b0; msb_first = 1'b0; p_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_chk++; if (p_out !== 4'h0) begin n_fail++; $display("FAIL reset_p_out: got %h expected 0", p_out); end
    n_chk++; if (p_valid !== 1'b0) begin n_fail++; $display("FAIL reset_p_valid: got %b expected 0", p_valid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_chk++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_msb_first();
    logic [W-1:0] seq;
    seq = 4'b1011;
    p_ready = 1'b1;
    for (int k = 0; k < W - 1; k++) drive_bit(seq[W-1-k], 1'b1);
    n_chk++; if (p_valid !== 1'b0) begin n_fail++; $display("FAIL msb_early_valid: got %b expected 0", p_valid); end
    drive_bit(seq[0], 1'b1);
`ifdef SHIFT_DESER_PARITY_EN
    drive_bit(^seq, 1'b1);
`endif
    n_chk++; if (p_valid !== 1'b1) begin n_fail++; $display("FAIL msb_valid: got %b expected 1", p_valid); end
    n_chk++; if (p_out !== exp_word(seq, 1'b1)) begin n_fail++; $display("FAIL msb_word: got %b expected %b", p_out, exp_word(seq, 1'b1)); end
    @(negedge clk);
    n_chk++; if (p_valid !== 1'b0) begin n_fail++; $display("FAIL msb_valid_drop: got %b expected 0", p_valid); end
  endtask

  task automatic test_lsb_first();
    send_seq(4'b1011, 1'b0, 1'b1);
    n_chk++; if (p_valid !== 1'b1 || p_out !== exp_word(4'b1011, 1'b0))
      begin n_fail++; $display("FAIL lsb_word: got %b/%b expected 1/%b", p_valid, p_out, exp_word(4'b1011, 1'b0)); end
    @(negedge clk);
  endtask

  task automatic test_gaps();
    logic [W-1:0] seq;
    seq = 4'b0110;
    for (int k = 0; k < NB; k++) begin
      drive_bit((k < W) ? seq[W-1-k] : ^seq, 1'b1);
      if (k < NB - 1) begin
        for (int g = 0; g < 3; g++) begin
          n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL gap_busy: bit %0d got %b expected 1", k, busy); end
          if (g < 2) @(negedge clk);
        end
      end
    end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL gap_busy_end: got %b expected 0", busy); end
    n_chk++; if (p_out !== exp_word(seq, 1'b1)) begin n_fail++; $display("FAIL gap_word: got %b expected %b", p_out, exp_word(seq, 1'b1)); end
    @(negedge clk);
  endtask

  task automatic test_overrun();
    p_ready = 1'b0;
    send_seq(4'hA, 1'b1, 1'b0);
    n_chk++; if (p_valid !== 1'b1 || overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_first: got valid %b ovr %b expected 1 0", p_valid, overrun); end
    send_seq(4'h5, 1'b1, 1'b0);
    n_chk++; if (p_out !== 4'hA) begin n_fail++; $display("FAIL ovr_hold: got %h expected a", p_out); end
    n_chk++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b expected 1", overrun); end
    repeat (2) @(negedge clk);
    n_chk++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_chk++; if (p_valid !== 1'b0 || overrun !== 1'b0 || p_out !== 4'h0)
      begin n_fail++; $display("FAIL clr: got valid %b ovr %b out %h expected 0 0 0", p_valid, overrun, p_out); end
    p_ready = 1'b1;
  endtask

  task automatic test_abort();
    p_ready = 1'b1;
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b0, 1'b1);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy: got %b expected 1", busy); end
    reset = 1'b0;
    #1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_async: got %b expected 0", busy); end
    @(negedge clk);
    reset = 1'b1;
    send_seq(4'b1110, 1'b1, 1'b0);
    n_chk++; if (p_valid !== 1'b1 || p_out !== 4'b1110) begin n_fail++; $display("FAIL abort_word: got %b/%b expected 1/1110", p_valid, p_out); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] seq;
    logic dir;
    p_ready = 1'b1;
    for (int n = 0; n < 24; n++) begin
      seq = W'($urandom);
      dir = 1'($urandom);
      send_seq(seq, dir, 1'($urandom));
      n_chk++; if (p_valid !== 1'b1 || p_out !== exp_word(seq, dir))
        begin n_fail++; $display("FAIL b2b_word %0d: got %b/%b expected 1/%b", n, p_valid, p_out, exp_word(seq, dir)); end
    end
    @(negedge clk);
  endtask

  // Random gaps and random p_ready; a word-level model of the single-entry buffer.
  task automatic test_handshake();
    logic [W-1:0] seq, m_o;
    logic dir, rdy, cmp, m_v, m_ovr;
    int g;
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    m_o = '0; m_v = 1'b0; m_ovr = 1'b0;
    for (int n = 0; n < 30; n++) begin
      seq = W'($urandom);
      dir = 1'($urandom);
      for (int k = 0; k < NB; k++) begin
        g = $urandom_range(0, 2);
        for (int j = 0; j <= g; j++) begin
          rdy = ($urandom_range(0, 3) != 0);
          cmp = (j == g) && (k == NB - 1);
          s_valid = (j == g); s_in = (k < W) ? seq[W-1-k] : ^seq; msb_first = dir; p_ready = rdy;
          @(negedge clk);
          s_valid = 1'b0;
          if (cmp) begin
            if (!m_v || rdy) begin m_o = exp_word(seq, dir); m_v = 1'b1; end
            else m_ovr = 1'b1;
          end else if (m_v && rdy) m_v = 1'b0;
          n_chk++;
          if (p_valid !== m_v || p_out !== m_o || overrun !== m_ovr) begin
            n_fail++;
            $display("FAIL hs word %0d: got v%b %b o%b expected v%b %b o%b", n, p_valid, p_out, overrun, m_v, m_o, m_ovr);
          end
        end
      end
    end
    p_ready = 1'b1;
    repeat (2) @(negedge clk);
  endtask

`ifdef SHIFT_DESER_PARITY_EN
  task automatic test_parity();
    p_ready = 1'b1;
    for (int p = 1; p >= 0; p--) begin
      drive_bit(1'b1, 1'b1); drive_bit(1'b0, 1'b1); drive_bit(1'b1, 1'b1); drive_bit(1'b1, 1'b1);
      drive_bit(1'(p), 1'b1);
      n_chk++; if (p_valid !== 1'b1 || p_out !== 4'b1011 || parity_err !== (p == 0))
        begin n_fail++; $display("FAIL parity p=%0d: got %b/%b err %b expected 1/1011 err %b", p, p_valid, p_out, parity_err, (p == 0)); end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_gaps();
    test_overrun();
    test_abort();
    test_back_to_back();
    test_handshake();
`ifdef SHIFT_DESER_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
